// File: rtl/shift_amt_ctrl_pkg.sv
// Shared types for the shift-amount controller: debounce states, button indices, amount ops.
package shift_amt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    PRESSED    = 2'd2,
    WAIT_REL   = 2'd3
  } db_state_t;

  typedef enum logic [1:0] {
    AMT_HOLD = 2'd0,
    AMT_CLR  = 2'd1,
    AMT_INC  = 2'd2,
    AMT_DEC  = 2'd3
  } amt_op_t;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CLR = 2;
  localparam int NUM_BTN = 3;

  // Clear dominates; opposing inc/dec in the same cycle cancel out.
  function automatic amt_op_t amt_op(input logic inc, input logic dec, input logic clr);
    if (clr)
      return AMT_CLR;
    if (inc && !dec)
      return AMT_INC;
    if (dec && !inc)
      return AMT_DEC;
    return AMT_HOLD;
  endfunction

endpackage

// File: rtl/shift_amt_ctrl_if.sv
// Button/amount bundle between the board buttons, the controller and the barrel shifter.
interface shift_amt_ctrl_if
  import shift_amt_ctrl_pkg::*;
#(
  parameter int AMT_W = 3
);
  logic [NUM_BTN-1:0] btn;
  logic [AMT_W-1:0]   amt;
  logic [NUM_BTN-1:0] btn_db;
  logic               amt_tick;

  modport master (output btn, input amt, input btn_db, input amt_tick);
  modport slave  (input btn, output amt, output btn_db, output amt_tick);
endinterface

// File: rtl/shift_amt_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser plus a four-state debounce FSM for one active-low button.
module btn_debounce
  import shift_amt_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic db_level,
  output logic press_tick
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  db_state_t     state;
  db_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          tick_nx;

  // Inversion happens ahead of the synchroniser so reset leaves it reading "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= ~btn_n;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      press_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      press_tick <= tick_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tick_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (sync_q2) begin
          state_nx = WAIT_PRESS;
          cnt_nx   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync_q2) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          tick_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q2) begin
          state_nx = WAIT_REL;
          cnt_nx   = '0;
        end
      end
      WAIT_REL: begin
        if (sync_q2) begin
          state_nx = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The level stays asserted until a release has fully qualified.
  always_comb begin
    db_level = (state == PRESSED) || (state == WAIT_REL);
  end

endmodule

// File: rtl/shift_amt_ctrl.sv
// Debounced inc/dec/clr buttons driving a registered shift amount for barrel_shifter_stage.
// Optional auto-repeat of inc/dec while held is enabled by defining BTN_AUTO_REPEAT_EN.
module shift_amt_ctrl
  import shift_amt_ctrl_pkg::*;
#(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_CYCLES = 12_500_000,
  parameter int AMT_W         = 3
) (
  input  logic            clk,
  input  logic            reset,
  shift_amt_ctrl_if.slave bus
);

  logic [NUM_BTN-1:0] db_level;
  logic [NUM_BTN-1:0] press_tick;
  logic               inc_ev;
  logic               dec_ev;
  logic               clr_ev;
  logic [AMT_W-1:0]   amt_q;
  logic               amt_tick_q;

  if (DB_CYCLES < 2 || REPEAT_CYCLES < 2 || AMT_W < 1) begin : g_bad_params
    $error("shift_amt_ctrl: DB_CYCLES and REPEAT_CYCLES must be >= 2, AMT_W >= 1");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .btn_n      (bus.btn[i]),
      .db_level   (db_level[i]),
      .press_tick (press_tick[i])
    );
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_tick;

  // Counting starts on the press edge, so the first repeat lands one full period after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        rep_cnt[r] <= '0;
      end
      rep_tick <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        rep_tick[r] <= 1'b0;
        if (!db_level[r]) begin
          rep_cnt[r] <= '0;
        end else if (rep_cnt[r] == REP_LAST) begin
          rep_cnt[r]  <= '0;
          rep_tick[r] <= 1'b1;
        end else begin
          rep_cnt[r] <= rep_cnt[r] + 1'b1;
        end
      end
    end
  end

  assign inc_ev = press_tick[BTN_INC] | rep_tick[BTN_INC];
  assign dec_ev = press_tick[BTN_DEC] | rep_tick[BTN_DEC];
`else
  assign inc_ev = press_tick[BTN_INC];
  assign dec_ev = press_tick[BTN_DEC];
`endif

  assign clr_ev = press_tick[BTN_CLR];

  // Wrap-around in both directions falls out of the modulo-2^AMT_W arithmetic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      amt_q      <= '0;
      amt_tick_q <= 1'b0;
    end else begin
      amt_tick_q <= 1'b0;
      case (amt_op(inc_ev, dec_ev, clr_ev))
        AMT_CLR: begin
          amt_q      <= '0;
          amt_tick_q <= 1'b1;
        end
        AMT_INC: begin
          amt_q      <= amt_q + 1'b1;
          amt_tick_q <= 1'b1;
        end
        AMT_DEC: begin
          amt_q      <= amt_q - 1'b1;
          amt_tick_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.amt      = amt_q;
  assign bus.amt_tick = amt_tick_q;
  assign bus.btn_db   = db_level;

endmodule

// File: tb/tb_shift_amt_ctrl.sv
// Directed bench for shift_amt_ctrl; expected amounts are queued at stimulus time and
// compared whenever amt_tick fires.
module tb_shift_amt_ctrl;
  import shift_amt_ctrl_pkg::*;

  localparam int DB    = 16;
  localparam int REP   = 64;
  localparam int AMT_W = 3;
  localparam int SETTLE = DB + 8;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;
  int tick_count  = 0;
  int t0;
  logic [AMT_W-1:0] model_amt;
  logic [AMT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  shift_amt_ctrl_if #(.AMT_W(AMT_W)) bus ();

  shift_amt_ctrl #(
    .DB_CYCLES     (DB),
    .REPEAT_CYCLES (REP),
    .AMT_W         (AMT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [NUM_BTN-1:0] btn_val);
    @(negedge clk);
    bus.btn = btn_val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.btn = 3'b111;
    wait_cycles(3);
    reset = 1'b0;
    model_amt = '0;
    exp_q.delete();
  endtask

  // Full press/release of one button, queueing the amount the model predicts.
  task automatic press(input int idx);
    logic [NUM_BTN-1:0] v;
    case (idx)
      BTN_INC: model_amt = model_amt + 1'b1;
      BTN_DEC: model_amt = model_amt - 1'b1;
      default: model_amt = '0;
    endcase
    exp_q.push_back(model_amt);
    v = 3'b111;
    v[idx] = 1'b0;
    apply_stimulus(v);
    wait_cycles(25);
    apply_stimulus(3'b111);
    wait_cycles(SETTLE);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.amt_tick) begin
      tick_count++;
      if (exp_q.size() == 0)
        check_output("tick_expected", exp_q.size(), 1);
      else
        check_output("amt_on_tick", bus.amt, exp_q.pop_front());
    end
  end

  initial begin
    reset   = 1'b1;
    bus.btn = 3'b111;

    // Reset state and first qualified increment.
    do_reset();
    check_output("reset_amt", bus.amt, 0);
    check_output("reset_btn_db", bus.btn_db, 0);
    check_output("reset_amt_tick", bus.amt_tick, 0);
    model_amt = 3'd1;
    exp_q.push_back(model_amt);
    apply_stimulus(3'b110);
    wait_cycles(19);
    check_output("inc_latency_amt", bus.amt, 0);
    check_output("inc_btn_db", bus.btn_db, 3'b001);
    wait_cycles(1);
    check_output("inc_amt", bus.amt, 1);
    check_output("inc_amt_tick", bus.amt_tick, 1);
    wait_cycles(1);
    check_output("inc_tick_pulse", bus.amt_tick, 0);
    wait_cycles(19);
    apply_stimulus(3'b111);
    wait_cycles(SETTLE);
    check_output("release_btn_db", bus.btn_db, 0);
    check_output("single_tick", tick_count, 1);

    // Short glitch never qualifies.
    do_reset();
    t0 = tick_count;
    apply_stimulus(3'b110);
    wait_cycles(10);
    check_output("glitch_btn_db_mid", bus.btn_db, 0);
    apply_stimulus(3'b111);
    wait_cycles(40);
    check_output("glitch_ticks", tick_count - t0, 0);
    check_output("glitch_amt", bus.amt, 0);
    check_output("glitch_btn_db", bus.btn_db, 0);

    // Wrap in both directions.
    do_reset();
    for (int k = 0; k < 7; k++) press(BTN_INC);
    check_output("amt_at_max", bus.amt, 7);
    t0 = tick_count;
    press(BTN_INC);
    check_output("inc_wrap", bus.amt, 0);
    check_output("inc_wrap_ticks", tick_count - t0, 1);
    press(BTN_DEC);
    check_output("dec_wrap", bus.amt, 7);
    check_output("dec_wrap_ticks", tick_count - t0, 2);

    // Simultaneous inc+dec cancel, then clear.
    do_reset();
    for (int k = 0; k < 5; k++) press(BTN_INC);
    check_output("amt_five", bus.amt, 5);
    t0 = tick_count;
    apply_stimulus(3'b100);
    wait_cycles(25);
    check_output("both_btn_db", bus.btn_db, 3'b011);
    apply_stimulus(3'b111);
    wait_cycles(SETTLE);
    check_output("both_amt", bus.amt, 5);
    check_output("both_ticks", tick_count - t0, 0);
    press(BTN_CLR);
    check_output("clr_amt", bus.amt, 0);
    check_output("clr_ticks", tick_count - t0, 1);

    // Reset mid-qualification with dec held through reset release.
    do_reset();
    t0 = tick_count;
    apply_stimulus(3'b101);
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(19);
    check_output("requal_no_tick", tick_count - t0, 0);
    check_output("requal_amt_hold", bus.amt, 0);
    model_amt = 3'd7;
    exp_q.push_back(model_amt);
    wait_cycles(1);
    check_output("requal_amt", bus.amt, 7);
    apply_stimulus(3'b111);
    wait_cycles(SETTLE);
    check_output("requal_ticks", tick_count - t0, 1);

    // Long hold of inc.
    do_reset();
    t0 = tick_count;
`ifdef BTN_AUTO_REPEAT_EN
    for (int k = 1; k <= 4; k++) exp_q.push_back(AMT_W'(k));
`else
    exp_q.push_back(3'd1);
`endif
    apply_stimulus(3'b110);
    wait_cycles(DB + 3 + 200);
    apply_stimulus(3'b111);
    wait_cycles(SETTLE);
`ifdef BTN_AUTO_REPEAT_EN
    check_output("hold_amt", bus.amt, 4);
    check_output("hold_ticks", tick_count - t0, 4);
`else
    check_output("hold_amt", bus.amt, 1);
    check_output("hold_ticks", tick_count - t0, 1);
`endif

    check_output("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
